// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results, runs one data-memory access at a
// time with a bounded wait, and reports misaligned or timed-out accesses.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_EX,
    input  logic        read_mem_EX,
    input  logic        wite_mem_EX,
    input  logic        wite_reg_EX,
    input  logic [4:0]  wite_reg_addr_EX,
    input  logic [31:0] ALU0_EX,
    input  logic [31:0] store_data_EX,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wite_reg_MEM,
    output logic        read_mem_MEM,
    output logic [4:0]  wite_reg_addr_MEM,
    output logic [31:0] ALU0_MEM,
    output logic [31:0] read_mem_data_MEM,
    output logic        misalign_MEM,
    output logic        bus_err_MEM
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Instruction parked for the duration of a bus access
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          store_q, store_d;
    logic          wreg_q, wreg_d;
    logic [RW-1:0] dest_q, dest_d;

    logic          wr_d, rm_d, mis_d, berr_d;
    logic [RW-1:0] dst_d;
    logic [DW-1:0] alu_d, rdat_d;

    logic mem_op;
    assign mem_op = read_mem_EX | wite_mem_EX;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        store_d = store_q;
        wreg_d  = wreg_q;
        dest_d  = dest_q;
        wr_d    = wite_reg_MEM;
        rm_d    = read_mem_MEM;
        dst_d   = wite_reg_addr_MEM;
        alu_d   = ALU0_MEM;
        rdat_d  = read_mem_data_MEM;
        mis_d   = 1'b0;
        berr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!valid_EX) begin
                    wr_d = 1'b0;
                    rm_d = 1'b0;
                end else if (!mem_op) begin
                    wr_d   = wite_reg_EX && (wite_reg_addr_EX != '0);
                    rm_d   = 1'b0;
                    dst_d  = wite_reg_addr_EX;
                    alu_d  = ALU0_EX;
                    rdat_d = '0;
                end else if (ALU0_EX[1:0] != 2'b00) begin
                    wr_d  = 1'b0;
                    rm_d  = 1'b0;
                    mis_d = 1'b1;
                end else begin
                    // A load+store combination is treated as a load
                    addr_d  = ALU0_EX;
                    wdata_d = store_data_EX;
                    store_d = wite_mem_EX & ~read_mem_EX;
                    wreg_d  = wite_reg_EX;
                    dest_d  = wite_reg_addr_EX;
                    cnt_d   = '0;
                    wr_d    = 1'b0;
                    rm_d    = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    dst_d   = dest_q;
                    alu_d   = addr_q;
                    if (store_q) begin
                        wr_d   = 1'b0;
                        rm_d   = 1'b0;
                        rdat_d = '0;
                    end else begin
                        wr_d   = wreg_q && (dest_q != '0);
                        rm_d   = 1'b1;
                        rdat_d = dmem_rdata;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    wr_d    = 1'b0;
                    rm_d    = 1'b0;
                    berr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    wr_d  = 1'b0;
                    rm_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            addr_q            <= '0;
            wdata_q           <= '0;
            store_q           <= 1'b0;
            wreg_q            <= 1'b0;
            dest_q            <= '0;
            wite_reg_MEM      <= 1'b0;
            read_mem_MEM      <= 1'b0;
            wite_reg_addr_MEM <= '0;
            ALU0_MEM          <= '0;
            read_mem_data_MEM <= '0;
            misalign_MEM      <= 1'b0;
            bus_err_MEM       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            addr_q            <= addr_d;
            wdata_q           <= wdata_d;
            store_q           <= store_d;
            wreg_q            <= wreg_d;
            dest_q            <= dest_d;
            wite_reg_MEM      <= wr_d;
            read_mem_MEM      <= rm_d;
            wite_reg_addr_MEM <= dst_d;
            ALU0_MEM          <= alu_d;
            read_mem_data_MEM <= rdat_d;
            misalign_MEM      <= mis_d;
            bus_err_MEM       <= berr_d;
        end
    end

    // Bus signals come straight from the state and parked registers, so they stay stable
    assign stall_MEM  = (state_q == ACCESS);
    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = (state_q == ACCESS) && store_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected instruction results are queued when an
// instruction is issued and compared when the stage delivers it.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_EX, read_mem_EX, wite_mem_EX, wite_reg_EX;
    logic [4:0]  wite_reg_addr_EX;
    logic [31:0] ALU0_EX, store_data_EX;
    logic        stall_MEM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wite_reg_MEM, read_mem_MEM;
    logic [4:0]  wite_reg_addr_MEM;
    logic [31:0] ALU0_MEM, read_mem_data_MEM;
    logic        misalign_MEM, bus_err_MEM;

    typedef struct packed {
        logic        wreg;
        logic        rmem;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rdata;
    } out_t;

    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .valid_EX(valid_EX), .read_mem_EX(read_mem_EX), .wite_mem_EX(wite_mem_EX),
        .wite_reg_EX(wite_reg_EX), .wite_reg_addr_EX(wite_reg_addr_EX),
        .ALU0_EX(ALU0_EX), .store_data_EX(store_data_EX),
        .stall_MEM(stall_MEM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wite_reg_MEM(wite_reg_MEM), .read_mem_MEM(read_mem_MEM),
        .wite_reg_addr_MEM(wite_reg_addr_MEM), .ALU0_MEM(ALU0_MEM),
        .read_mem_data_MEM(read_mem_data_MEM),
        .misalign_MEM(misalign_MEM), .bus_err_MEM(bus_err_MEM)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic wreg,
                          input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] sd);
        valid_EX         = v;
        read_mem_EX      = rd;
        wite_mem_EX      = wr;
        wite_reg_EX      = wreg;
        wite_reg_addr_EX = dest;
        ALU0_EX          = alu;
        store_data_EX    = sd;
    endtask

    task automatic sb_pop(input string tag);
        out_t e, o;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '{wite_reg_MEM, read_mem_MEM, wite_reg_addr_MEM, ALU0_MEM, read_mem_data_MEM};
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        step();
        step();
        chk("rst_stall", 32'(stall_MEM), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wreg", 32'(wite_reg_MEM), 32'd0);
        chk("rst_alu", ALU0_MEM, 32'h0);
        chk("rst_exc", 32'({misalign_MEM, bus_err_MEM}), 32'd0);
        rst = 1'b0;

        // ALU pass-through
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h10, 32'h0);
        exp_q.push_back('{1'b1, 1'b0, 5'd3, 32'h10, 32'h0});
        step();
        chk("alu_stall", 32'(stall_MEM), 32'd0);
        sb_pop("alu_out");

        // Destination 0 never writes; a stray ack in IDLE changes nothing
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h77, 32'h0);
        dmem_ack = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 5'd0, 32'h77, 32'h0});
        step();
        dmem_ack = 1'b0;
        sb_pop("r0_out");
        chk("idle_ack_stall", 32'(stall_MEM), 32'd0);

        // Bubble: control cleared, data held
        set_ex(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 32'h0);
        exp_q.push_back('{1'b0, 1'b0, 5'd0, 32'h77, 32'h0});
        step();
        sb_pop("bubble_out");

        // Load with three wait cycles
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0);
        exp_q.push_back('{1'b1, 1'b1, 5'd7, 32'h100, 32'hDEADBEEF});
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("ld_accept_bubble", 32'(wite_reg_MEM), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 32'(stall_MEM), 32'd1);
            chk("ld_addr", dmem_addr, 32'h100);
            chk("ld_req_we", 32'({dmem_req, dmem_we}), 32'd2);
            if (i == 2) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            step();
        end
        dmem_ack = 1'b0;
        sb_pop("ld_out");
        chk("ld_done_stall", 32'(stall_MEM), 32'd0);

        // Store with immediate ack
        set_ex(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h20, 32'h55);
        exp_q.push_back('{1'b0, 1'b0, 5'd9, 32'h20, 32'h0});
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_wdata", dmem_wdata, 32'h55);
        chk("st_addr", dmem_addr, 32'h20);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        sb_pop("st_out");
        chk("st_done_req", 32'({dmem_req, dmem_we}), 32'd0);

        // Misaligned load: exception pulse, no bus activity
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h102, 32'h0);
        exp_q.push_back('{1'b0, 1'b0, 5'd9, 32'h20, 32'h0});
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("mis_pulse", 32'(misalign_MEM), 32'd1);
        chk("mis_req", 32'({dmem_req, stall_MEM}), 32'd0);
        sb_pop("mis_out");
        step();
        chk("mis_pulse_end", 32'(misalign_MEM), 32'd0);

        // Load that never completes; held ALU op issues after the abort
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h40, 32'h0);
        step();
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hABC, 32'h0);
        n = 0;
        while (stall_MEM && n < 40) begin
            chk("to_bubble", 32'(wite_reg_MEM | bus_err_MEM), 32'd0);
            n++;
            step();
        end
        chk("to_cycles", 32'(n), 32'd15);
        chk("to_bus_err", 32'(bus_err_MEM), 32'd1);
        chk("to_wreg", 32'(wite_reg_MEM), 32'd0);
        exp_q.push_back('{1'b1, 1'b0, 5'd4, 32'hABC, 32'h0});
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("to_pulse_end", 32'(bus_err_MEM), 32'd0);
        sb_pop("held_out");

        // Ack on the last permitted cycle beats the timeout
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h80, 32'h0);
        exp_q.push_back('{1'b1, 1'b1, 5'd6, 32'h80, 32'h12345678});
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            chk("late_stall", 32'(stall_MEM), 32'd1);
            if (i == 14) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'h12345678;
            end
            step();
        end
        dmem_ack = 1'b0;
        chk("late_no_err", 32'(bus_err_MEM), 32'd0);
        sb_pop("late_out");

        // Reset on the second access cycle discards the load silently
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h200, 32'h0);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        step();
        chk("rst_acc_stall_pre", 32'(stall_MEM), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_acc_req", 32'({dmem_req, stall_MEM}), 32'd0);
        chk("rst_acc_outs", 32'({wite_reg_MEM, read_mem_MEM, wite_reg_addr_MEM}), 32'd0);
        chk("rst_acc_data", ALU0_MEM | read_mem_data_MEM, 32'h0);
        chk("rst_acc_exc", 32'({misalign_MEM, bus_err_MEM}), 32'd0);
        step();
        chk("rst_acc_after", 32'({dmem_req, misalign_MEM, bus_err_MEM}), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
